iloveyou_gen: RTL

Stimulus-side counterpart of the `check_iloveyou0` detector. It emits the phrase "iloveyou" one letter per slot on the two 8-bit ASCII letter streams `cap_flow` (uppercase) and `low_flow` (lowercase), with per-letter case selection and configurable filler gaps. Filler letters come from an LFSR and never include a phrase letter. The block drives the detector's inputs in system-level benches and in the on-board demo.

---
 rtl/iloveyou_gen.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/iloveyou_gen.sv
// iloveyou_gen: emits "iloveyou" one letter per slot on cap/low ASCII buses
// with per-letter case, LFSR filler (never a phrase letter) and filler gaps.
// Ports: clk, rst_n (sync, active-low), start, gap_len, case_mask, reps in;
//        cap_flow, low_flow, valid, on_cap, letter_idx, busy, done out.
module iloveyou_gen #(
  parameter int GAP_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [7:0]       case_mask,
  input  logic [REP_W-1:0] reps,
  output logic [7:0]       cap_flow,
  output logic [7:0]       low_flow,
  output logic             valid,
  output logic             on_cap,
  output logic [2:0]       letter_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [7:0]       mask_q, mask_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [2:0]       idx_q, idx_d;

  logic [7:0] cap_q, cap_d;
  logic [7:0] low_q, low_d;
  logic       valid_q, valid_d;
  logic       oncap_q, oncap_d;
  logic [2:0] lidx_q, lidx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] fill_cap, fill_low, ph_low;
  logic       last;

  function automatic logic [7:0] phrase(input logic [2:0] i);
    unique case (i)
      3'd0: phrase = 8'h69;
      3'd1: phrase = 8'h6C;
      3'd2: phrase = 8'h6F;
      3'd3: phrase = 8'h76;
      3'd4: phrase = 8'h65;
      3'd5: phrase = 8'h79;
      3'd6: phrase = 8'h6F;
      default: phrase = 8'h75;
    endcase
  endfunction

  // Consonants only, so filler can never alias a phrase letter.
  function automatic logic [7:0] filler(input logic [3:0] i);
    unique case (i)
      4'd0:  filler = 8'h42;
      4'd1:  filler = 8'h43;
      4'd2:  filler = 8'h44;
      4'd3:  filler = 8'h46;
      4'd4:  filler = 8'h47;
      4'd5:  filler = 8'h48;
      4'd6:  filler = 8'h4A;
      4'd7:  filler = 8'h4B;
      4'd8:  filler = 8'h4D;
      4'd9:  filler = 8'h4E;
      4'd10: filler = 8'h50;
      4'd11: filler = 8'h51;
      4'd12: filler = 8'h52;
      4'd13: filler = 8'h53;
      4'd14: filler = 8'h54;
      default: filler = 8'h57;
    endcase
  endfunction

  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    // Filler tracks the LFSR value being loaded alongside the outputs.
    fill_cap = filler(lfsr_d[3:0]);
    fill_low = filler(lfsr_d[7:4]) + 8'd32;
    ph_low   = phrase(idx_q);
    last     = (idx_q == 3'd7) && (rep_q == reps_q);

    state_d = state_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    mask_d  = mask_q;
    reps_d  = reps_q;
    rep_d   = rep_q;
    idx_d   = idx_q;

    cap_d   = 8'h41;
    low_d   = 8'h61;
    valid_d = 1'b0;
    oncap_d = 1'b0;
    lidx_d  = lidx_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          gap_d   = gap_len;
          mask_d  = case_mask;
          reps_d  = (reps == '0) ? REP_W'(1) : reps;
          rep_d   = REP_W'(1);
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        lidx_d  = idx_q;
        oncap_d = mask_q[idx_q];
        if (mask_q[idx_q]) begin
          cap_d = ph_low - 8'd32;
          low_d = fill_low;
        end else begin
          cap_d = fill_cap;
          low_d = ph_low;
        end
        if (last) begin
          state_d = DONE;
        end else if (gap_q != '0) begin
          gcnt_d  = gap_q;
          state_d = GAP;
        end else begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) rep_d = rep_q + REP_W'(1);
        end
      end
      GAP: begin
        busy_d = 1'b1;
        cap_d  = fill_cap;
        low_d  = fill_low;
        if (gcnt_q == GAP_W'(1)) begin
          state_d = SEND;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) rep_d = rep_q + REP_W'(1);
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      default: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= 8'hA5;
      gap_q   <= '0;
      gcnt_q  <= '0;
      mask_q  <= '0;
      reps_q  <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      cap_q   <= 8'h41;
      low_q   <= 8'h61;
      valid_q <= 1'b0;
      oncap_q <= 1'b0;
      lidx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      mask_q  <= mask_d;
      reps_q  <= reps_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      low_q   <= low_d;
      valid_q <= valid_d;
      oncap_q <= oncap_d;
      lidx_q  <= lidx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cap_flow   = cap_q;
  assign low_flow   = low_q;
  assign valid      = valid_q;
  assign on_cap     = oncap_q;
  assign letter_idx = lidx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
